// File: rtl/data_mem_responder.sv
// Word-addressed data memory for the CPU load/store path.
// Zero-fills itself after reset while holding the pipeline in halt.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_ACCESS_READ_WRN,
  input  logic [15:0] MEM_ACCESS_ADDRESS_BUS,
  input  logic [31:0] MEM_ACCESS_DATA_OUT_BUS,
  output logic [31:0] MEM_ACCESS_DATA_IN_BUS,
  output logic        halt,
  output logic        mem_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [16:0] LIMIT = 17'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   clr_cnt_q;
  logic [31:0]     rdata_q;
  logic            halt_q;
  logic            err_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic            in_range;
  logic            aligned;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [31:0]     wdata;

  assign idx      = MEM_ACCESS_ADDRESS_BUS[AW+1:2];
  assign in_range = {1'b0, MEM_ACCESS_ADDRESS_BUS} < LIMIT;
  assign aligned  = MEM_ACCESS_ADDRESS_BUS[1:0] == 2'b00;

  // Single write port shared by the clear sweep and CPU stores
  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wdata = MEM_ACCESS_DATA_OUT_BUS;
    if (state_q == CLEAR) begin
      we    = rst_n;
      waddr = clr_cnt_q;
      wdata = 32'h0;
    end else if (!MEM_ACCESS_READ_WRN && in_range && aligned) begin
      we    = 1'b1;
    end
  end

  // No reset here: contents change only through the write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ON_RESET ? CLEAR : READY;
      halt_q    <= CLEAR_ON_RESET;
      clr_cnt_q <= '0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          rdata_q   <= 32'h0;
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST) begin
            state_q <= READY;
            halt_q  <= 1'b0;
          end
        end
        READY: begin
          if (MEM_ACCESS_READ_WRN) begin
            if (in_range) begin
              rdata_q <= mem_q[idx];
            end else begin
              rdata_q <= 32'h0;
              err_q   <= 1'b1;
            end
          end else if (!in_range || !aligned) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q <= READY;
        end
      endcase
    end
  end

  assign MEM_ACCESS_DATA_IN_BUS = rdata_q;
  assign halt                   = halt_q;
  assign mem_err                = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at DEPTH_WORDS=16.
// Inputs change on negedge; outputs are checked on the following negedge.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        rw;
  logic [15:0] addr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        halt;
  logic        mem_err;

  int n_run;
  int n_fail;

  data_mem_responder #(
    .DEPTH_WORDS(16),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .MEM_ACCESS_READ_WRN    (rw),
    .MEM_ACCESS_ADDRESS_BUS (addr),
    .MEM_ACCESS_DATA_OUT_BUS(wdat),
    .MEM_ACCESS_DATA_IN_BUS (rdat),
    .halt                   (halt),
    .mem_err                (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, sample at the next negedge
  task automatic cyc(input logic r, input logic [15:0] a,
                     input logic [31:0] d);
    rw   = r;
    addr = a;
    wdat = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [15:0] a);
    cyc(1'b1, a, 32'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    cyc(1'b0, a, d);
  endtask

  // Count halt cycles, issuing writes that must be ignored
  task automatic count_clear(input string tag);
    int n;
    n = 0;
    while (halt && n < 100) begin
      check({tag, "_rdat_in_clear"}, rdat, 32'h0);
      wr(16'(4 * (n % 16)), 32'hDEAD_BEEF);
      n++;
    end
    check({tag, "_halt_cycles"}, 32'(n), 32'd16);
    check({tag, "_err_after_clear"}, {31'h0, mem_err}, 32'h0);
  endtask

  task automatic all_zero(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd(16'(4 * i));
      check($sformatf("%s_w%0d", tag, i), rdat, 32'h0);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    rw     = 1'b1;
    addr   = 16'h0;
    wdat   = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_rdat", rdat, 32'h0);
    check("rst_halt", {31'h0, halt}, 32'h1);
    check("rst_err", {31'h0, mem_err}, 32'h0);

    rst_n = 1'b1;
    count_clear("clr1");
    all_zero("zero1");

    wr(16'h0008, 32'hCAFE_F00D);
    rd(16'h0008);
    check("wr_rd_8", rdat, 32'hCAFE_F00D);

    wr(16'h0004, 32'h1111_1111);
    check("hold_on_write", rdat, 32'hCAFE_F00D);
    wr(16'h0004, 32'h2222_2222);
    rd(16'h0004);
    check("b2b_rd_4", rdat, 32'h2222_2222);
    rd(16'h0006);
    check("misalign_rd_6", rdat, 32'h2222_2222);
    check("misalign_no_err", {31'h0, mem_err}, 32'h0);

    wr(16'h0040, 32'h4040_4040);
    check("oor_wr_err", {31'h0, mem_err}, 32'h1);
    rd(16'h0000);
    check("oor_wr_dropped", rdat, 32'h0);
    rd(16'h0040);
    check("oor_rd_zero", rdat, 32'h0);
    wr(16'h0005, 32'h5555_5555);
    rd(16'h0004);
    check("misalign_wr_dropped", rdat, 32'h2222_2222);
    repeat (3) rd(16'h0008);
    check("err_sticky", {31'h0, mem_err}, 32'h1);

    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_err", {31'h0, mem_err}, 32'h0);
    check("rst2_halt", {31'h0, halt}, 32'h1);
    rst_n = 1'b1;
    repeat (7) wr(16'h0008, 32'hBAD0_BAD0);
    check("mid_halt", {31'h0, halt}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_clear("clr2");
    all_zero("zero2");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words stored; power of two, 16 to 16384.
REQ-002 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill the array after reset, 0 = skip the fill.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port MEM_ACCESS_READ_WRN, input, 1 bit: 1 = read, 0 = write.
REQ-006 SHALL have port MEM_ACCESS_ADDRESS_BUS, input, 16 bits: byte address.
REQ-007 SHALL have port MEM_ACCESS_DATA_OUT_BUS, input, 32 bits: CPU write data.
REQ-008 SHALL have port MEM_ACCESS_DATA_IN_BUS, output, 32 bits: registered read data to the CPU.
REQ-009 SHALL have port halt, output, 1 bit: stalls the CPU pipeline while high.
REQ-010 SHALL have port mem_err, output, 1 bit: sticky access-error flag.

Function
REQ-011 Word index SHALL be ADDRESS_BUS[log2(DEPTH_WORDS)+1:2].
REQ-012 An address is in range when ADDRESS_BUS < 4*DEPTH_WORDS.
REQ-013 The FSM SHALL have states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, otherwise READY.
REQ-014 CLEAR behaviour:
- clear counter starts at 0 and writes 32'h0 to one word per cycle, counter 0..DEPTH_WORDS-1;
- after writing word DEPTH_WORDS-1 the FSM enters READY;
- total time in CLEAR is exactly DEPTH_WORDS cycles.
REQ-015 halt SHALL be 1 in CLEAR and 0 in READY.
REQ-016 While in CLEAR, CPU writes SHALL be ignored, DATA_IN_BUS SHALL be 0, and mem_err SHALL NOT be set.
REQ-017 In READY, every cycle with READ_WRN=1 SHALL be a read; DATA_IN_BUS SHALL present the addressed word on the next rising edge (1-cycle latency) and hold it until the next read.
REQ-018 In READY with READ_WRN=0 and an in-range, word-aligned address (ADDRESS_BUS[1:0]=0), DATA_OUT_BUS SHALL be written to the word on that edge.
REQ-019 Write data SHALL be a full 32-bit word; sign-extension and sub-word selection stay in the CPU.
REQ-020 A read of a word written on the immediately preceding edge SHALL return the new data; no stale-data window.
REQ-021 A misaligned read SHALL return the aligned word, with no error.
REQ-022 A misaligned or out-of-range write SHALL be dropped and SHALL set mem_err.
REQ-023 An out-of-range read SHALL return 32'h0 and SHALL set mem_err.
REQ-024 mem_err SHALL stay at 1 until reset; no other clear path exists.
REQ-025 During a write cycle, DATA_IN_BUS SHALL hold its previous value.
REQ-026 Reset mid-CLEAR SHALL restart the clear counter at 0.
REQ-027 Reset in READY SHALL re-run CLEAR when CLEAR_ON_RESET=1.
REQ-028 Array contents SHALL NOT be touched by the asynchronous reset itself; only the CLEAR sequence zeroes them.

Reset
REQ-029 While rst_n=0:
- DATA_IN_BUS = 32'h0;
- halt = 1 if CLEAR_ON_RESET=1, else 0;
- mem_err = 0;
- clear counter = 0;
- FSM = CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-030 Release of rst_n SHALL take effect on the first rising clk edge after release; no extra synchroniser latency inside this block.

Verification (DEPTH_WORDS=16)
REQ-031 Clear: release rst_n -> halt=1 for exactly 16 cycles, then 0; reads of every address 0x00..0x3C return 32'h0.
REQ-032 Write/read: write 32'hCAFE_F00D at 0x0008; next cycle read 0x0008 -> DATA_IN_BUS=32'hCAFE_F00D one edge later.
REQ-033 Back-to-back: write 32'h1111_1111 at 0x0004 then 32'h2222_2222 at 0x0004 on consecutive edges, then read 0x0004 -> 32'h2222_2222; read 0x0006 -> same word, mem_err=0.
REQ-034 Errors:
- write to 0x0040 -> dropped, mem_err=1;
- read 0x0040 -> 32'h0;
- write to 0x0005 -> dropped;
- mem_err stays 1 until rst_n=0.
REQ-035 Clear-window writes: writes issued while halt=1 -> contents still 0 after CLEAR.
REQ-036 Mid-clear reset: pulse rst_n low at clear cycle 7 -> halt stays 1 for 16 further cycles after release; all words read 0.
